// File: rtl/uart_frame_assembler.sv
// Collects UART RX bytes (low byte first) into a flat frame of signed words and holds the frame
// behind a valid/ack handshake; flags inter-byte timeouts and bytes dropped while a frame is held.
module uart_frame_assembler #(
    parameter int unsigned FFT_SIZE       = 16,
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned DATA_LENGTH    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    localparam int unsigned BPF           = FFT_SIZE * WORD_SIZE / DATA_LENGTH,
    localparam int unsigned CNT_W         = $clog2(BPF + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_LENGTH-1:0]        i_byte,
    input  logic                          i_byte_valid,
    input  logic                          i_frame_ack,
    output logic [FFT_SIZE*WORD_SIZE-1:0] o_frame,
    output logic                          o_frame_valid,
    output logic [CNT_W-1:0]              o_byte_count,
    output logic                          o_timeout,
    output logic                          o_overflow
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StFull
    } state_e;

    state_e            state;
    logic [IDLE_W-1:0] idle_cnt;

    // Word size is a whole number of bytes, so byte n lands at bit n*DATA_LENGTH of the flat bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= StIdle;
            o_frame       <= '0;
            o_frame_valid <= 1'b0;
            o_byte_count  <= '0;
            o_timeout     <= 1'b0;
            o_overflow    <= 1'b0;
            idle_cnt      <= '0;
        end else begin
            o_timeout <= 1'b0;
            unique case (state)
                StIdle: begin
                    idle_cnt <= '0;
                    if (i_byte_valid) begin
                        o_frame[0 +: DATA_LENGTH] <= i_byte;
                        o_byte_count              <= CNT_W'(1);
                        state                     <= StCollect;
                    end
                end
                StCollect: begin
                    if (i_byte_valid) begin
                        o_frame[o_byte_count * DATA_LENGTH +: DATA_LENGTH] <= i_byte;
                        o_byte_count <= o_byte_count + 1'b1;
                        idle_cnt     <= '0;
                        if (o_byte_count == CNT_W'(BPF - 1)) begin
                            o_frame_valid <= 1'b1;
                            state         <= StFull;
                        end
                    end else if (idle_cnt >= IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                        // This is the TIMEOUT_CYCLES-th idle clock: abandon the partial frame.
                        o_timeout    <= 1'b1;
                        o_byte_count <= '0;
                        idle_cnt     <= '0;
                        state        <= StIdle;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                StFull: begin
                    idle_cnt <= '0;
                    if (i_frame_ack) begin
                        o_frame_valid <= 1'b0;
                        o_overflow    <= 1'b0;
                        if (i_byte_valid) begin
                            o_frame[0 +: DATA_LENGTH] <= i_byte;
                            o_byte_count              <= CNT_W'(1);
                            state                     <= StCollect;
                        end else begin
                            o_byte_count <= '0;
                            state        <= StIdle;
                        end
                    end else if (i_byte_valid) begin
                        o_overflow <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
